// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures div_in period/high time and tracks lock to DIV (optional CLK_DIV_MONITOR_SYNC_EN input synchronizer)
module clk_div_monitor #(
  parameter int DIV      = 5,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(2 * DIV);
  localparam logic [CNT_W-1:0] H_LO  = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] H_HI  = CNT_W'((DIV + 1) / 2);
  localparam logic [4:0]       LCK_C = 5'(LOCK_CNT);
  state_t           state_q, state_d;
  logic             s_q, prev_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [3:0]       good_q, good_d;
  logic             mv_q, mv_d, err_q, err_d;
  logic             rise, active, good, timeout;
  logic [4:0]       good_inc;
`ifdef CLK_DIV_MONITOR_SYNC_EN
  logic [1:0] sync_q;
  // two-flop synchronizer ahead of the sample flop, then edge-detect history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      s_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], div_in};
      s_q    <= sync_q[1];
      prev_q <= s_q;
    end
`else
  // single sample flop, then edge-detect history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s_q    <= div_in;
      prev_q <= s_q;
    end
`endif
  assign rise     = s_q & ~prev_q;
  assign active   = state_q != IDLE;
  assign good     = pcnt_q == DIV_C && (hcnt_q == H_LO || hcnt_q == H_HI);
  assign timeout  = active && !rise && pcnt_q == TO_C;
  assign good_inc = {1'b0, good_q} + 5'd1;
  // period/high counters: restart on rise, idle at zero, saturate at all-ones
  always_comb begin
    pcnt_d = rise ? ONE : (!active || timeout) ? '0 : (pcnt_q == ONES) ? pcnt_q : pcnt_q + ONE;
    hcnt_d = rise ? ONE : (!active || timeout) ? '0 : (s_q && hcnt_q != ONES) ? hcnt_q + ONE : hcnt_q;
  end
  // next state, measurement capture and error/lock decisions; rise wins over timeout
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    err_d    = 1'b0;
    if (rise) begin
      if (!active) state_d = MEASURE;
      else begin
        mv_d     = 1'b1;
        period_d = pcnt_q;
        high_d   = hcnt_q;
        if (!good) begin
          err_d   = 1'b1;
          good_d  = '0;
          state_d = MEASURE;
        end else if (state_q == MEASURE) begin
          good_d  = good_inc[3:0];
          state_d = (good_inc >= LCK_C) ? LOCKED : MEASURE;
        end
      end
    end else if (timeout) begin
      err_d   = 1'b1;
      good_d  = '0;
      state_d = IDLE;
    end
  end
  // state and measurement registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      good_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      err_q    <= err_d;
    end
  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = mv_q;
  assign err        = err_q;
  assign locked     = state_q == LOCKED;
endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL provide parameter DIV, default 5, meaning the expected division ratio in clk cycles per div_in period (legal range 2..127).
REQ-002 SHALL provide parameter LOCK_CNT, default 4, meaning the number of consecutive good periods required to assert locked (legal range 1..15).
REQ-003 SHALL provide parameter CNT_W, default 8, meaning the width of the measurement counters and outputs (must hold 2*DIV).
REQ-004 SHALL provide ports: clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 div_in  input  1  divided clock under test, treated as a data signal.
REQ-007 period_out  output  CNT_W  last measured rise-to-rise distance in clk cycles.
REQ-008 high_out  output  CNT_W  clk cycles div_in sampled high within the last period.
REQ-009 meas_valid  output  1  one-cycle pulse, asserted when period_out/high_out update.
REQ-010 locked  output  1  level; div_in matches DIV with correct duty.
REQ-011 err  output  1  one-cycle pulse on a bad period or timeout.

Function
REQ-012 SHALL sample div_in into s (direct, or through synchronizer per REQ-029), keep prev = s delayed one cycle, and define rise = s & ~prev.
REQ-013 SHALL implement states IDLE, MEASURE, LOCKED; IDLE waits for the first rise, moving to MEASURE with no measurement emitted.
REQ-014 SHALL keep period counter pcnt: loaded 1 on a rise cycle, else incremented, saturating at all-ones; held at 0 in IDLE.
REQ-015 SHALL keep high counter hcnt: loaded 1 on a rise cycle, else incremented when s=1, saturating.
REQ-016 SHALL, on a rise in MEASURE or LOCKED, register period_out=pcnt and high_out=hcnt and pulse meas_valid one cycle later (latency 1 clk from rise).
REQ-017 SHALL deem a period good when pcnt==DIV and hcnt is floor(DIV/2) or ceil(DIV/2).
REQ-018 SHALL count consecutive good periods in good_cnt; on reaching LOCK_CNT enter LOCKED and assert locked on the same cycle as meas_valid.
REQ-019 SHALL, on a bad period, pulse err with meas_valid, clear good_cnt, deassert locked, and go to MEASURE (the bad rise still starts the next period).
REQ-020 SHALL, when pcnt reaches 2*DIV in MEASURE or LOCKED with no rise, pulse err once, clear good_cnt, deassert locked, and return to IDLE (stuck div_in).
REQ-021 SHALL give rise priority over timeout when both occur on the same cycle.
REQ-022 SHALL hold period_out and high_out between updates; they are not cleared by errors.
REQ-023 SHALL keep locked asserted across good periods in LOCKED without re-counting.

Reset
REQ-024 SHALL, while rst=1, force state=IDLE, prev=0, s=0, pcnt=0, hcnt=0, good_cnt=0.
REQ-025 SHALL reset outputs to period_out=0, high_out=0, meas_valid=0, locked=0, err=0.
REQ-026 SHALL, on rst asserted mid-operation, drop locked and abort any pending measurement asynchronously.
REQ-027 SHALL, after reset release, require a fresh first rise plus LOCK_CNT good periods before locked.

Configuration
REQ-028 SHALL use macro CLK_DIV_MONITOR_SYNC_EN.
REQ-029 With the macro defined, div_in SHALL pass a two-flop synchronizer (reset to 0) before s, adding 2 clk of latency to all responses; without it, s = div_in registered once (1 flop).
REQ-030 Pass/fail criteria (REQ-017, REQ-020) SHALL be identical in both builds.

Verification
REQ-031 DIV=5, LOCK_CNT=4: 50%-duty divide-by-5 stimulus from rst release -> meas_valid every 5 clk with period_out=5, high_out=2 or 3; locked rises on the 4th meas_valid, err never.
REQ-032 Locked, then one period of 6 clk -> err and meas_valid same cycle, period_out=6, locked=0; 4 further good periods -> locked=1.
REQ-033 Locked, div_in held 0 -> err pulse exactly once when pcnt reaches 10, locked=0, state IDLE, no meas_valid.
REQ-034 Period 5 with high 1 clk -> period_out=5, high_out=1, err pulse, good_cnt cleared.
REQ-035 rst pulsed while locked -> all outputs 0 immediately; relock after first rise + 4 good periods.
REQ-036 Repeat REQ-031 with CLK_DIV_MONITOR_SYNC_EN defined -> same values, every meas_valid 2 clk later.
